// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decodes the ID opcode, carries controls through EX/MEM/WB,
// and resolves RAW hazards. Define CTRL_FWD_EN to enable operand forwarding.
module ctrl_pipe_unit #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [6:0]         id_opcode,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               ex_flush,
    input  logic               mem_stall,
    output logic               id_stall,
    output logic               ex_valid,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_branch,
    output logic               ex_jal,
    output logic               ex_jalr,
    output logic               ex_illegal,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_AW-1:0]  wb_rd,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef struct packed {
        logic               valid;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               branch;
        logic               jal;
        logic               jalr;
        logic               illegal;
        logic               mem_read;
        logic               mem_write;
        logic               regwrite;
        logic               memtoreg;
        logic [REG_AW-1:0]  rd;
    } ex_t;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              regwrite;
        logic              memtoreg;
        logic [REG_AW-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [REG_AW-1:0] rd;
    } wb_t;

    ex_t  dec, ex_r;
    mem_t mem_r;
    wb_t  wb_r;
    logic uses_rs1, uses_rs2;
    logic ex_hit, hazard;

    always_comb begin
        dec      = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        if (id_valid) begin
            dec.valid = 1'b1;
            case (id_opcode)
                OP_R:     begin dec.aluop = ALUOP_W'(2'b10); dec.regwrite = 1'b1;
                                uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                OP_I:     begin dec.alusrc = 1'b1; dec.aluop = ALUOP_W'(2'b10);
                                dec.regwrite = 1'b1; uses_rs1 = 1'b1; end
                OP_LW:    begin dec.alusrc = 1'b1; dec.mem_read = 1'b1; dec.memtoreg = 1'b1;
                                dec.regwrite = 1'b1; uses_rs1 = 1'b1; end
                OP_SW:    begin dec.alusrc = 1'b1; dec.mem_write = 1'b1;
                                uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                OP_BR:    begin dec.aluop = ALUOP_W'(2'b01); dec.branch = 1'b1;
                                uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                OP_LUI:   begin dec.alusrc = 1'b1; dec.aluop = ALUOP_W'(2'b11);
                                dec.regwrite = 1'b1; end
                OP_AUIPC: begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
                OP_JAL:   begin dec.jal = 1'b1; dec.regwrite = 1'b1; end
                OP_JALR:  begin dec.alusrc = 1'b1; dec.jalr = 1'b1; dec.regwrite = 1'b1;
                                uses_rs1 = 1'b1; end
                default:  dec.illegal = 1'b1;
            endcase
            // rd is carried only for writers, so non-writers can never look like producers
            if (dec.regwrite) dec.rd = id_rd;
        end
    end

    assign ex_hit = ex_r.valid && (ex_r.rd != '0) &&
                    (((ex_r.rd == id_rs1) && uses_rs1) || ((ex_r.rd == id_rs2) && uses_rs2));

`ifdef CTRL_FWD_EN
    logic [REG_AW-1:0] ex_rs1, ex_rs2;

    assign hazard = ex_hit && ex_r.mem_read && id_valid && !ex_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else if (!mem_stall) begin
            ex_rs1 <= (ex_flush || hazard || !uses_rs1) ? '0 : id_rs1;
            ex_rs2 <= (ex_flush || hazard || !uses_rs2) ? '0 : id_rs2;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (mem_r.regwrite && (mem_r.rd != '0) && (mem_r.rd == rs))   return 2'b10;
        else if (wb_r.regwrite && (wb_r.rd != '0) && (wb_r.rd == rs)) return 2'b01;
        else                                                          return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(ex_rs1);
    assign fwd_b = fwd_sel(ex_rs2);
`else
    logic mem_hit;

    assign mem_hit = mem_r.regwrite && (mem_r.rd != '0) &&
                     (((mem_r.rd == id_rs1) && uses_rs1) || ((mem_r.rd == id_rs2) && uses_rs2));
    assign hazard  = ((ex_hit && ex_r.regwrite) || mem_hit) && id_valid && !ex_flush;
    assign fwd_a   = 2'b00;
    assign fwd_b   = 2'b00;
`endif

    assign id_stall = !reset && (mem_stall || hazard);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else if (!mem_stall) begin
            ex_r  <= (ex_flush || hazard) ? '0 : dec;
            mem_r <= '{mem_read: ex_r.mem_read, mem_write: ex_r.mem_write,
                       regwrite: ex_r.regwrite, memtoreg: ex_r.memtoreg, rd: ex_r.rd};
            wb_r  <= '{regwrite: mem_r.regwrite, memtoreg: mem_r.memtoreg, rd: mem_r.rd};
        end
    end

    assign ex_valid    = ex_r.valid;
    assign ex_alusrc   = ex_r.alusrc;
    assign ex_aluop    = ex_r.aluop;
    assign ex_branch   = ex_r.branch;
    assign ex_jal      = ex_r.jal;
    assign ex_jalr     = ex_r.jalr;
    assign ex_illegal  = ex_r.illegal;
    assign mem_read    = mem_r.mem_read;
    assign mem_write   = mem_r.mem_write;
    assign wb_regwrite = wb_r.regwrite;
    assign wb_memtoreg = wb_r.memtoreg;
    assign wb_rd       = wb_r.rd;
endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: decode table streamed through a fixed-latency scoreboard,
// plus hand sequences for hazards, flush, memory stall and reset.
module tb_ctrl_pipe_unit;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam int NV = 12;

    logic clk = 1'b0;
    logic reset, id_valid, ex_flush, mem_stall;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic id_stall, ex_valid, ex_alusrc, ex_branch, ex_jal, ex_jalr, ex_illegal;
    logic mem_read, mem_write, wb_regwrite, wb_memtoreg;
    logic [1:0] ex_aluop, fwd_a, fwd_b;
    logic [4:0] wb_rd;

    always #5 clk = ~clk;

    ctrl_pipe_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_flush(ex_flush),
        .mem_stall(mem_stall), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_illegal(ex_illegal),
        .mem_read(mem_read), .mem_write(mem_write), .wb_regwrite(wb_regwrite),
        .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    // e = {illegal, alusrc, aluop[1:0], branch, jal, jalr, mem_read, mem_write, regwrite, memtoreg}
    typedef struct {
        logic        v;
        logic [6:0]  op;
        logic [10:0] e;
    } vec_t;

    vec_t       vecs[NV];
    logic [4:0] rd_tab[NV], rs1_tab[NV], rs2_tab[NV];
    logic [7:0] ex_q[$];
    logic [1:0] mem_q[$];
    logic [6:0] wb_q[$];
    logic [7:0] last_ex;
    logic [1:0] last_mem;
    logic [6:0] last_wb;
    logic       froze;
    int checks = 0, errors = 0;
    int n_stall, exp_stall;
    logic [1:0] exp_fwd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [22:0] all_out();
        return {id_stall, ex_valid, ex_alusrc, ex_aluop, ex_branch, ex_jal, ex_jalr, ex_illegal,
                mem_read, mem_write, wb_regwrite, wb_memtoreg, wb_rd, fwd_a, fwd_b};
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
            ex_flush = 1'b0; mem_stall = 1'b0;
        end
    endtask

    task automatic sample_stages();
        if (!froze) begin
            last_ex = ex_q.pop_front(); last_mem = mem_q.pop_front(); last_wb = wb_q.pop_front();
        end
        check("ex_bundle", {ex_valid, ex_illegal, ex_alusrc, ex_aluop, ex_branch, ex_jal, ex_jalr},
              last_ex);
        check("mem_bundle", {mem_read, mem_write}, last_mem);
        check("wb_ctrl", {wb_regwrite, wb_memtoreg}, last_wb[6:5]);
        if (last_wb[6]) check("wb_rd", wb_rd, last_wb[4:0]);
        froze = 1'b0;
    endtask

    task automatic push_vec(input int i);
        logic [10:0] e;
        e = vecs[i].v ? vecs[i].e : 11'd0;
        ex_q.push_back({vecs[i].v, e[10:4]});
        mem_q.push_back(e[3:2]);
        wb_q.push_back({e[1:0], e[1] ? rd_tab[i] : 5'd0});
    endtask

    initial begin
        vecs[0]  = '{1'b1, OP_R,     11'b0_0_10_000_00_10};
        vecs[1]  = '{1'b1, OP_SW,    11'b0_1_00_000_01_00};
        vecs[2]  = '{1'b1, OP_I,     11'b0_1_10_000_00_10};
        vecs[3]  = '{1'b1, OP_LW,    11'b0_1_00_000_10_11};
        vecs[4]  = '{1'b1, OP_BR,    11'b0_0_01_100_00_00};
        vecs[5]  = '{1'b1, OP_LUI,   11'b0_1_11_000_00_10};
        vecs[6]  = '{1'b1, OP_AUIPC, 11'b0_1_00_000_00_10};
        vecs[7]  = '{1'b1, 7'h7f,    11'b1_0_00_000_00_00};
        vecs[8]  = '{1'b1, OP_JAL,   11'b0_0_00_010_00_10};
        vecs[9]  = '{1'b1, OP_JALR,  11'b0_1_00_001_00_10};
        vecs[10] = '{1'b0, OP_R,     11'b0_0_00_000_00_00};
        vecs[11] = '{1'b1, 7'h00,    11'b1_0_00_000_00_00};
        for (int i = 0; i < NV; i++) begin
            // destinations 1..15 and sources 20..31 keep the stream hazard-free
            rd_tab[i]  = (i == 0) ? 5'd1 : 5'($urandom_range(4, 15));
            rs1_tab[i] = (i == 0) ? 5'd2 : 5'($urandom_range(20, 31));
            rs2_tab[i] = (i == 0) ? 5'd3 : 5'($urandom_range(20, 31));
        end

        // reset with random inputs
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            ex_flush = 1'($urandom_range(0, 1)); mem_stall = 1'($urandom_range(0, 1));
            @(posedge clk); @(negedge clk);
            check("reset_outputs", {9'd0, all_out()}, 32'd0);
        end
        @(negedge clk); reset = 1'b0;
        idle(3);

        // decode stream through the scoreboard, with a 3-cycle memory stall mid-stream
        ex_q = {8'd0}; mem_q = {2'd0, 2'd0}; wb_q = {7'd0, 7'd0, 7'd0};
        froze = 1'b0;
        for (int i = 0; i < NV + 3; i++) begin
            if (i == 5) begin
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    sample_stages();
                    drive(vecs[i].v, vecs[i].op, rs1_tab[i], rs2_tab[i], rd_tab[i]);
                    mem_stall = 1'b1; froze = 1'b1;
                    #1 check("stall_id_stall", id_stall, 1'b1);
                end
            end
            @(negedge clk);
            sample_stages();
            mem_stall = 1'b0;
            if (i < NV) begin
                drive(vecs[i].v, vecs[i].op, rs1_tab[i], rs2_tab[i], rd_tab[i]);
                push_vec(i);
            end else begin
                drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
                ex_q.push_back(8'd0); mem_q.push_back(2'd0); wb_q.push_back(7'd0);
            end
            #1 check("stream_id_stall", id_stall, 1'b0);
        end
        idle(3);

        // load-use: lw x5 ; add x6,x5,x7
`ifdef CTRL_FWD_EN
        exp_stall = 1; exp_fwd = 2'b01;
`else
        exp_stall = 2; exp_fwd = 2'b00;
`endif
        @(negedge clk); drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5);
        @(negedge clk); drive(1'b1, OP_R, 5'd5, 5'd7, 5'd6);
        #1;
        n_stall = 0;
        while (id_stall === 1'b1 && n_stall < 8) begin
            @(posedge clk); #1;
            n_stall++;
            if (n_stall == 1) check("lu_bubble", ex_valid, 1'b0);
        end
        check("lu_stall_cycles", n_stall, exp_stall);
        @(posedge clk); #1;
        check("lu_add_in_ex", {ex_valid, ex_aluop}, 3'b110);
        check("lu_fwd_a", fwd_a, exp_fwd);
        check("lu_fwd_b", fwd_b, 2'b00);
        idle(4);

        // x0 destination never hazards
        @(negedge clk); drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd0);
        @(negedge clk); drive(1'b1, OP_R, 5'd0, 5'd0, 5'd6);
        #1 check("x0_no_stall", id_stall, 1'b0);
        @(posedge clk); #1 check("x0_add_issued", ex_valid, 1'b1);
        idle(4);

        // flush coinciding with load-use
        @(negedge clk); drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5);
        @(negedge clk); drive(1'b1, OP_R, 5'd5, 5'd7, 5'd6); ex_flush = 1'b1;
        #1 check("flush_no_stall", id_stall, 1'b0);
        @(negedge clk);
        check("flush_bubble", {ex_valid, mem_read}, 2'b01);
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0); ex_flush = 1'b0;
        @(negedge clk);
        check("flush_lw_wb", {wb_regwrite, wb_rd, mem_read, mem_write}, {1'b1, 5'd5, 2'b00});
        @(negedge clk);
        check("flush_no_write", {wb_regwrite, mem_write}, 2'b00);
        idle(3);

        // reset asserted mid-stall
        @(negedge clk); drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd9);
        @(negedge clk); drive(1'b1, OP_R, 5'd9, 5'd0, 5'd10); mem_stall = 1'b1;
        #1 check("rst_stall_before", id_stall, 1'b1);
        @(negedge clk); reset = 1'b1;
        #1 check("rst_stall_drop", id_stall, 1'b0);
        @(negedge clk);
        check("rst_mid_stall_clear", {9'd0, all_out()}, 32'd0);
        reset = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
